// File: rtl/quarter_wave_sincos.sv
// Quadrature sine/cosine lookup: one quarter wave in a two-port ROM, full period by address folding.
// Valid/ready handshake with a fixed pipeline that stalls as a whole when the output is blocked.
module quarter_wave_sincos #(
  parameter int PHASE_W = 12,
  parameter int DATA_W  = 16,
  parameter int AMPL    = 2**(DATA_W-1) - 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [PHASE_W-1:0]    i_tdata,
  input  logic                  i_tvalid,
  output logic                  i_tready,
  output logic [2*DATA_W-1:0]   o_tdata,
  output logic                  o_tvalid,
  input  logic                  o_tready
);

  localparam int  IDX_W  = PHASE_W - 2;
  localparam int  Q      = 2**IDX_W;
  localparam real TWO_PI = 6.283185307179586;

  // Quarter-wave table sampled at half-step offsets, so entries k and Q-1-k mirror exactly.
  logic [DATA_W-1:0] rom_tbl [Q];

  for (genvar k = 0; k < Q; k++) begin : g_rom
    localparam real ANG = TWO_PI * (real'(k) + 0.5) / real'(2**PHASE_W);
    localparam int  VAL = $rtoi(real'(AMPL) * $sin(ANG) + 0.5);
    assign rom_tbl[k] = VAL[DATA_W-1:0];
  end

  logic en;
  assign en       = ~o_tvalid | o_tready;
  assign i_tready = en & ~clear;

  // Stage registers: s0 holds the phase, s1 the folded addresses and signs,
  // s2 the ROM data (the ROM read takes s1 -> s2), then the output register.
  logic               v0, v1, v2;
  logic [PHASE_W-1:0] ph0;
  logic [IDX_W-1:0]   addr_s1, addr_c1;
  logic               neg_s1, neg_c1, neg_s2, neg_c2;
  logic [DATA_W-1:0]  rom_s2, rom_c2;

  logic [1:0]       quad;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] addr_s, addr_c;
  logic             neg_s, neg_c;

  assign quad   = ph0[PHASE_W-1 -: 2];
  assign idx    = ph0[IDX_W-1:0];
  // Odd quadrants read the table backwards; cosine is sine one quadrant ahead.
  assign addr_s = quad[0] ? ~idx : idx;
  assign addr_c = quad[0] ? idx : ~idx;
  assign neg_s  = quad[1];
  assign neg_c  = quad[1] ^ quad[0];

  logic [DATA_W-1:0] sin_val, cos_val;
  assign sin_val = neg_s2 ? -rom_s2 : rom_s2;
  assign cos_val = neg_c2 ? -rom_c2 : rom_c2;

  // Valid chain: clear beats the handshake, reset beats everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v0       <= 1'b0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      o_tvalid <= 1'b0;
    end else if (clear) begin
      v0       <= 1'b0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      o_tvalid <= 1'b0;
    end else if (en) begin
      v0       <= i_tvalid;
      v1       <= v0;
      v2       <= v1;
      o_tvalid <= v2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_tdata <= '0;
    end else if (en) begin
      o_tdata <= {cos_val, sin_val};
    end
  end

  // NOTE: internal datapath registers carry no reset; their contents only matter
  // when the matching valid bit is set, and the valid chain is reset.
  always_ff @(posedge clk) begin
    if (en) begin
      ph0     <= i_tdata;
      addr_s1 <= addr_s;
      addr_c1 <= addr_c;
      neg_s1  <= neg_s;
      neg_c1  <= neg_c;
      rom_s2  <= rom_tbl[addr_s1];
      rom_c2  <= rom_tbl[addr_c1];
      neg_s2  <= neg_s1;
      neg_c2  <= neg_c1;
    end
  end

endmodule

// File: doc/quarter_wave_sincos.md
Name: quarter_wave_sincos

Overview:
- Parametrised quadrature sine/cosine lookup: a phase word in, a signed sine and cosine pair out.
- Stores one quarter wave in an internal dual-read ROM and reconstructs the full period by address folding and sign restoration.
- Uses an AXI-stream-style valid/ready handshake with a fixed 3-cycle pipeline and whole-pipeline stall.
- Sits between phase generators (NCO/DDS accumulators) and mixers or DAC test-pattern paths in the radio datapath.

Parameters:
- PHASE_W, 12: phase input width. Full period = 2^PHASE_W steps. Minimum 4.
- DATA_W, 16: width of each signed output sample. Range 8..18.
- AMPL, 2^(DATA_W-1)-1: peak amplitude of ROM contents. Must be ≤ 2^(DATA_W-1)-1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous pipeline flush, active-high.
- i_tdata  in  PHASE_W  unsigned phase.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  2*DATA_W  {cos[DATA_W-1:0], sin[DATA_W-1:0]}, two's complement.
- o_tvalid  out  1  output valid.
- o_tready  in  1  downstream ready.

Behaviour:
- **ROM.** Depth Q = 2^(PHASE_W-2), two read ports, registered read. Entry k = round(AMPL * sin(2π(k+0.5)/2^PHASE_W)). The half-step offset makes the fold exact with no duplicated endpoints. Contents are computed at elaboration; no external init file.
- **Decode.** Quadrant q = phase[PHASE_W-1:PHASE_W-2]; idx = phase[PHASE_W-3:0]; ~idx = bitwise inverse.
- **Sine by quadrant.** q0: +rom[idx]; q1: +rom[~idx]; q2: -rom[idx]; q3: -rom[~idx].
- **Cosine by quadrant** (quadrant q+1 mod 4). q0: +rom[~idx]; q1: -rom[idx]; q2: -rom[~idx]; q3: +rom[idx].
- **Arithmetic.** Negation is two's complement on DATA_W bits. It cannot overflow because |entry| ≤ AMPL. No saturation logic. Outputs are never -2^(DATA_W-1).
- **Pipeline** (3 stages, each with its own valid bit):
  - S0: register phase, compute fold addresses and negate flags.
  - S1: ROM read; negate flags delayed to stay aligned with ROM data.
  - S2: apply signs; register o_tdata and o_tvalid.
- **Enable and stall.**
  - en = ~o_tvalid | o_tready. i_tready = en, combinational.
  - When en=0 all stages hold data and valid; the ROM read port must also hold its output (use a read enable).
  - When en=1 every stage shifts, and bubbles propagate as valid=0.
  - Latency: a sample accepted at edge N appears on o_tdata/o_tvalid after edge N+3 if no stall. Throughput is 1 sample/clk.
  - o_tdata stays stable while o_tvalid=1 and o_tready=0.
- **Reset** (reset_n=0, any time including mid-stream):
  - All valid bits → 0 immediately; o_tvalid=0.
  - o_tdata=0; i_tready=1 (follows en).
  - In-flight samples are discarded. The first sample after release follows normal latency.
- **Clear** (clear=1 at an edge): all valid bits → 0 at that edge. The input beat presented that cycle is not accepted and i_tready=0 while clear=1. Data registers may keep stale values.
- **Simultaneous events.**
  - Input accepted on the same edge that output drains: both happen, pipeline stays full.
  - clear takes precedence over the handshake.
  - reset_n takes precedence over everything.
- **Wrap-around.** Phase 2^PHASE_W-1 followed by 0 is continuous; no special handling.
- **Data independence.** No state depends on data values; only the valid and stall path is sequential control.

Test Plan:
- **Defaults, quadrant points, o_tready=1.** Phases 0, 1024, 2048, 3072 accepted back-to-back → outputs 3 cycles later, one per cycle:
  - (sin,cos) = (25,32767)
  - (32767,-25)
  - (-25,-32767)
  - (-32767,25)
- **Full sweep.** Phases 0..4095 → every output within ±1 LSB of round(32767·sin/cos(2π(p+0.5)/4096)). sin(p) = -sin(p+2048) exactly. No value equals -32768.
- **Backpressure.** Stream 0..15 continuously with o_tready toggled pseudo-randomly → outputs in order with no loss or duplication. o_tdata is held stable every cycle where o_tvalid=1 and o_tready=0. i_tready=0 exactly when o_tvalid=1 and o_tready=0.
- **Mid-stream reset.** Drop reset_n asynchronously (between edges) with 3 samples in flight → o_tvalid=0 immediately, o_tdata=0. After release, phase 1024 gives (32767,-25) 3 cycles after acceptance; no stale output appears.
- **Clear.** Pulse clear for 1 cycle with the pipeline full and o_tready=0 → o_tvalid=0 next cycle. The beat offered during clear is not accepted (i_tready=0). Subsequent samples flow normally.
- **Minimum width.** PHASE_W=4, DATA_W=8: sweep phases 0..15 → sin(0)=round(127·sin(π/16))=25, sin(4)=cos(0)=round(127·cos(π/16))=125; all 16 pairs match the formula exactly.
